// File: rtl/alu_op_pkg.sv
// Shared ALU control definitions for the ID/EX stage and the ALU.
//   - ALU op codes (4-bit)
//   - MIPS opcode and funct field values decoded by alu_op_decode
//   - ALU operand select encodings
//   - alu_ctrl_t: packed control word produced by the decoder
package alu_op_pkg;

    // ALU op codes
    localparam logic [3:0] AluAdd   = 4'h0;
    localparam logic [3:0] AluSub   = 4'h1;
    localparam logic [3:0] AluAnd   = 4'h2;
    localparam logic [3:0] AluOr    = 4'h3;
    localparam logic [3:0] AluSrl   = 4'h4;
    localparam logic [3:0] AluSra   = 4'h5;
    localparam logic [3:0] AluSll   = 4'h6;
    localparam logic [3:0] AluSlt   = 4'h7;
    localparam logic [3:0] AluSltu  = 4'h8;
    localparam logic [3:0] AluNor   = 4'h9;
    localparam logic [3:0] AluXor   = 4'hA;
    localparam logic [3:0] AluPassA = 4'hB;
    localparam logic [3:0] AluPassB = 4'hC;
    localparam logic [3:0] AluRotr  = 4'hD;

    // Primary opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpSltiu = 6'h0B;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSra  = 6'h03;
    localparam logic [5:0] FnSllv = 6'h04;
    localparam logic [5:0] FnSrlv = 6'h06;
    localparam logic [5:0] FnSrav = 6'h07;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;
    localparam logic [5:0] FnSltu = 6'h2B;

    // Operand selects
    localparam logic       ASelRs    = 1'b0;
    localparam logic       ASelShamt = 1'b1;
    localparam logic [1:0] BSelRt    = 2'd0;
    localparam logic [1:0] BSelImm   = 2'd1;
    localparam logic [1:0] BSelLui   = 2'd2;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       a_sel;
        logic [1:0] b_sel;
        logic       ext_sign;
        logic       ov_en;
        logic       rw_en;
        logic [4:0] waddr;
        logic       illegal;
    } alu_ctrl_t;

    // Control word for a reserved instruction: ADD, no write, no trap.
    function automatic alu_ctrl_t ctrl_illegal();
        alu_ctrl_t c;
        c         = '0;
        c.alu_op  = AluAdd;
        c.illegal = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS instruction decoder producing the ALU control word.
// Ports:
//   instr_i  32-bit instruction word
//   ctrl_o   decoded alu_ctrl_t (rw_en already cleared when waddr is 0)
module alu_op_decode
    import alu_op_pkg::*;
(
    input  logic [31:0] instr_i,
    output alu_ctrl_t   ctrl_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic       ill;

    assign opcode = instr_i[31:26];
    assign rs     = instr_i[25:21];
    assign rt     = instr_i[20:16];
    assign rd     = instr_i[15:11];
    assign shamt  = instr_i[10:6];
    assign funct  = instr_i[5:0];

    always_comb begin
        ctrl_o = '0;
        ill    = 1'b0;

        if (opcode == OpRtype) begin
            ctrl_o.waddr = rd;
            ctrl_o.b_sel = BSelRt;
            ctrl_o.rw_en = 1'b1;
            case (funct)
                FnAdd:  begin ctrl_o.alu_op = AluAdd; ctrl_o.ov_en = 1'b1; end
                FnAddu: ctrl_o.alu_op = AluAdd;
                FnSub:  begin ctrl_o.alu_op = AluSub; ctrl_o.ov_en = 1'b1; end
                FnSubu: ctrl_o.alu_op = AluSub;
                FnAnd:  ctrl_o.alu_op = AluAnd;
                FnOr:   ctrl_o.alu_op = AluOr;
                FnXor:  ctrl_o.alu_op = AluXor;
                FnNor:  ctrl_o.alu_op = AluNor;
                FnSlt:  ctrl_o.alu_op = AluSlt;
                FnSltu: ctrl_o.alu_op = AluSltu;
                // Immediate shifts: the rs field must be exactly as listed.
                FnSll: begin
                    ctrl_o.alu_op = AluSll;
                    ctrl_o.a_sel  = ASelShamt;
                    ill           = (rs != 5'd0);
                end
                FnSrl: begin
                    ctrl_o.a_sel = ASelShamt;
                    if (rs == 5'd0)      ctrl_o.alu_op = AluSrl;
                    else if (rs == 5'd1) ctrl_o.alu_op = AluRotr;
                    else                 ill = 1'b1;
                end
                FnSra: begin
                    ctrl_o.alu_op = AluSra;
                    ctrl_o.a_sel  = ASelShamt;
                    ill           = (rs != 5'd0);
                end
                // Variable shifts: shamt selects SRL vs ROTR.
                FnSllv: ctrl_o.alu_op = AluSll;
                FnSrlv: begin
                    if (shamt == 5'd0)      ctrl_o.alu_op = AluSrl;
                    else if (shamt == 5'd1) ctrl_o.alu_op = AluRotr;
                    else                    ill = 1'b1;
                end
                FnSrav: ctrl_o.alu_op = AluSra;
                default: ill = 1'b1;
            endcase
        end else begin
            ctrl_o.waddr    = rt;
            ctrl_o.b_sel    = BSelImm;
            ctrl_o.rw_en    = 1'b1;
            ctrl_o.ext_sign = 1'b1;
            case (opcode)
                OpAddi:  begin ctrl_o.alu_op = AluAdd; ctrl_o.ov_en = 1'b1; end
                OpAddiu: ctrl_o.alu_op = AluAdd;
                OpSlti:  ctrl_o.alu_op = AluSlt;
                OpSltiu: ctrl_o.alu_op = AluSltu;
                OpAndi:  begin ctrl_o.alu_op = AluAnd; ctrl_o.ext_sign = 1'b0; end
                OpOri:   begin ctrl_o.alu_op = AluOr;  ctrl_o.ext_sign = 1'b0; end
                OpXori:  begin ctrl_o.alu_op = AluXor; ctrl_o.ext_sign = 1'b0; end
                OpLui: begin
                    ctrl_o.alu_op   = AluPassB;
                    ctrl_o.b_sel    = BSelLui;
                    ctrl_o.ext_sign = 1'b0;
                end
                OpLw:    ctrl_o.alu_op = AluAdd;
                OpSw: begin
                    ctrl_o.alu_op = AluAdd;
                    ctrl_o.rw_en  = 1'b0;
                end
                OpBeq, OpBne: begin
                    ctrl_o.alu_op = AluSub;
                    ctrl_o.b_sel  = BSelRt;
                    ctrl_o.rw_en  = 1'b0;
                end
                default: ill = 1'b1;
            endcase
        end

        if (ill) begin
            ctrl_o = ctrl_illegal();
        end

        // $0 is hardwired; a write to it is not a write.
        if (ctrl_o.waddr == 5'd0) begin
            ctrl_o.rw_en = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_alu_ctrl.sv
// ID->EX pipeline register carrying the decoded ALU control word.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   instr_i, pc_i      instruction and its PC from IF/ID
//   valid_i            instruction is real (0 = bubble)
//   stall, flush       hold stage / insert bubble (flush wins)
//   valid_o, pc_o      registered valid flag and PC
//   alu_op_o ..        registered ALU control outputs
//   rs_o .. imm_o      registered instruction fields
//   illegal_o          reserved-instruction exception
module id_ex_alu_ctrl
    import alu_op_pkg::*;
#(
    parameter int unsigned         PC_W     = 32,
    parameter logic [PC_W-1:0]     RESET_PC = 32'h0000_3000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            valid_i,
    input  logic            stall,
    input  logic            flush,
    output logic            valid_o,
    output logic [PC_W-1:0] pc_o,
    output logic [3:0]      alu_op_o,
    output logic            a_sel_o,
    output logic [1:0]      b_sel_o,
    output logic            ext_sign_o,
    output logic            ov_en_o,
    output logic            rw_en_o,
    output logic [4:0]      waddr_o,
    output logic [4:0]      rs_o,
    output logic [4:0]      rt_o,
    output logic [4:0]      shamt_o,
    output logic [15:0]     imm_o,
    output logic            illegal_o
);

    alu_ctrl_t       dec_ctrl;
    alu_ctrl_t       ctrl_d;
    alu_ctrl_t       ctrl_q;
    logic            valid_q;
    logic [PC_W-1:0] pc_q;
    logic [4:0]      rs_q;
    logic [4:0]      rt_q;
    logic [4:0]      shamt_q;
    logic [15:0]     imm_q;

    alu_op_decode u_decode (
        .instr_i (instr_i),
        .ctrl_o  (dec_ctrl)
    );

    // A bubble must never write, trap or raise an exception downstream.
    always_comb begin
        ctrl_d = dec_ctrl;
        if (!valid_i) begin
            ctrl_d.rw_en   = 1'b0;
            ctrl_d.ov_en   = 1'b0;
            ctrl_d.illegal = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            shamt_q <= '0;
            imm_q   <= '0;
        end else if (flush) begin
            // PC is kept so exception logic still sees a sensible address.
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            shamt_q <= '0;
            imm_q   <= '0;
        end else if (!stall) begin
            valid_q <= valid_i;
            pc_q    <= pc_i;
            ctrl_q  <= ctrl_d;
            rs_q    <= instr_i[25:21];
            rt_q    <= instr_i[20:16];
            shamt_q <= instr_i[10:6];
            imm_q   <= instr_i[15:0];
        end
    end

    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign alu_op_o   = ctrl_q.alu_op;
    assign a_sel_o    = ctrl_q.a_sel;
    assign b_sel_o    = ctrl_q.b_sel;
    assign ext_sign_o = ctrl_q.ext_sign;
    assign ov_en_o    = ctrl_q.ov_en;
    assign rw_en_o    = ctrl_q.rw_en;
    assign waddr_o    = ctrl_q.waddr;
    assign illegal_o  = ctrl_q.illegal;
    assign rs_o       = rs_q;
    assign rt_o       = rt_q;
    assign shamt_o    = shamt_q;
    assign imm_o      = imm_q;

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Directed bench for id_ex_alu_ctrl with hand-computed expected values.
module tb_id_ex_alu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        valid_i;
    logic        stall;
    logic        flush;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [3:0]  alu_op_o;
    logic        a_sel_o;
    logic [1:0]  b_sel_o;
    logic        ext_sign_o;
    logic        ov_en_o;
    logic        rw_en_o;
    logic [4:0]  waddr_o;
    logic [4:0]  rs_o;
    logic [4:0]  rt_o;
    logic [4:0]  shamt_o;
    logic [15:0] imm_o;
    logic        illegal_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_alu_ctrl #(
        .PC_W     (32),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .valid_i    (valid_i),
        .stall      (stall),
        .flush      (flush),
        .valid_o    (valid_o),
        .pc_o       (pc_o),
        .alu_op_o   (alu_op_o),
        .a_sel_o    (a_sel_o),
        .b_sel_o    (b_sel_o),
        .ext_sign_o (ext_sign_o),
        .ov_en_o    (ov_en_o),
        .rw_en_o    (rw_en_o),
        .waddr_o    (waddr_o),
        .rs_o       (rs_o),
        .rt_o       (rt_o),
        .shamt_o    (shamt_o),
        .imm_o      (imm_o),
        .illegal_o  (illegal_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_ctrl(input string tag, input logic v, input logic [3:0] op,
                               input logic asel, input logic [1:0] bsel, input logic ext,
                               input logic ov, input logic rw, input logic [4:0] wa,
                               input logic ill);
        check({tag, ".valid"},   32'(valid_o),    32'(v));
        check({tag, ".alu_op"},  32'(alu_op_o),   32'(op));
        check({tag, ".a_sel"},   32'(a_sel_o),    32'(asel));
        check({tag, ".b_sel"},   32'(b_sel_o),    32'(bsel));
        check({tag, ".ext"},     32'(ext_sign_o), 32'(ext));
        check({tag, ".ov_en"},   32'(ov_en_o),    32'(ov));
        check({tag, ".rw_en"},   32'(rw_en_o),    32'(rw));
        check({tag, ".waddr"},   32'(waddr_o),    32'(wa));
        check({tag, ".illegal"}, 32'(illegal_o),  32'(ill));
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v);
        instr_i = ins;
        pc_i    = pc;
        valid_i = v;
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(32'h0, 32'h0, 1'b0);
        #1;
        expect_ctrl("reset", 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        check("reset.pc", pc_o, 32'h0000_3000);
        check("reset.imm", 32'(imm_o), 32'h0);
        #1 reset = 1'b0;

        // addi $8,$9,-1
        drive(32'h2128_FFFF, 32'h100, 1'b1);
        step();
        expect_ctrl("addi", 1'b1, 4'h0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
        check("addi.rs", 32'(rs_o), 32'd9);
        check("addi.rt", 32'(rt_o), 32'd8);
        check("addi.imm", 32'(imm_o), 32'hFFFF);
        check("addi.pc", pc_o, 32'h100);

        // rotr $2,$3,4
        drive(32'h0023_1102, 32'h104, 1'b1);
        step();
        expect_ctrl("rotr", 1'b1, 4'hD, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0);
        check("rotr.shamt", 32'(shamt_o), 32'd4);

        // rs=2 on funct 02 is reserved
        drive(32'h0043_1102, 32'h108, 1'b1);
        step();
        check("rotr_bad.illegal", 32'(illegal_o), 32'd1);
        check("rotr_bad.rw_en", 32'(rw_en_o), 32'd0);
        check("rotr_bad.ov_en", 32'(ov_en_o), 32'd0);
        check("rotr_bad.alu_op", 32'(alu_op_o), 32'h0);

        // lui $1,0xABCD
        drive(32'h3C01_ABCD, 32'h10C, 1'b1);
        step();
        check("lui.alu_op", 32'(alu_op_o), 32'hC);
        check("lui.b_sel", 32'(b_sel_o), 32'd2);
        check("lui.waddr", 32'(waddr_o), 32'd1);
        check("lui.rw_en", 32'(rw_en_o), 32'd1);
        check("lui.imm", 32'(imm_o), 32'hABCD);

        // nop decodes as SLL with no write
        drive(32'h0000_0000, 32'h110, 1'b1);
        step();
        expect_ctrl("nop", 1'b1, 4'h6, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        // sub $2,$3,$4
        drive(32'h0064_1022, 32'h114, 1'b1);
        step();
        expect_ctrl("sub", 1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0);

        // sltiu $10,$8,5
        drive(32'h2D0A_0005, 32'h118, 1'b1);
        step();
        expect_ctrl("sltiu", 1'b1, 4'h8, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);

        // ori $8,$8,0xFF
        drive(32'h3508_00FF, 32'h11C, 1'b1);
        step();
        expect_ctrl("ori", 1'b1, 4'h3, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);

        // rotrv $3,$2,$1 (shamt=1), then shamt=2 is reserved
        drive(32'h0022_1846, 32'h120, 1'b1);
        step();
        expect_ctrl("rotrv", 1'b1, 4'hD, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
        drive(32'h0022_1886, 32'h124, 1'b1);
        step();
        check("rotrv_bad.illegal", 32'(illegal_o), 32'd1);
        check("rotrv_bad.rw_en", 32'(rw_en_o), 32'd0);

        // sw $9,4($8)
        drive(32'hAD09_0004, 32'h128, 1'b1);
        step();
        expect_ctrl("sw", 1'b1, 4'h0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0);

        // beq $8,$9,+3
        drive(32'h1109_0003, 32'h12C, 1'b1);
        step();
        check("beq.alu_op", 32'(alu_op_o), 32'h1);
        check("beq.b_sel", 32'(b_sel_o), 32'd0);
        check("beq.rw_en", 32'(rw_en_o), 32'd0);

        // Bubble: addi with valid_i=0 must not write or trap
        drive(32'h2128_FFFF, 32'h130, 1'b0);
        step();
        check("bubble.valid", 32'(valid_o), 32'd0);
        check("bubble.rw_en", 32'(rw_en_o), 32'd0);
        check("bubble.ov_en", 32'(ov_en_o), 32'd0);
        // Bubble carrying a reserved word must not raise an exception
        drive(32'hFC00_0000, 32'h134, 1'b0);
        step();
        check("bubble_ill.illegal", 32'(illegal_o), 32'd0);

        // addu $3,$4,$5 then stall 3 cycles while instr_i changes
        drive(32'h0085_1821, 32'h200, 1'b1);
        step();
        expect_ctrl("addu", 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h0064_1022 + 32'(i), 32'h300 + 32'(i * 4), 1'b0);
            step();
            expect_ctrl("stall", 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
            check("stall.pc", pc_o, 32'h200);
            check("stall.rs", 32'(rs_o), 32'd4);
        end

        // Stall with flush: flush wins, PC held
        drive(32'h2128_FFFF, 32'h400, 1'b1);
        flush = 1'b1;
        step();
        check("flush.valid", 32'(valid_o), 32'd0);
        check("flush.rw_en", 32'(rw_en_o), 32'd0);
        check("flush.pc", pc_o, 32'h200);
        stall = 1'b0;
        flush = 1'b0;

        // Opcode 0x3F is reserved
        drive(32'hFC00_0000, 32'h404, 1'b1);
        step();
        check("op3f.valid", 32'(valid_o), 32'd1);
        check("op3f.illegal", 32'(illegal_o), 32'd1);
        check("op3f.rw_en", 32'(rw_en_o), 32'd0);
        check("op3f.alu_op", 32'(alu_op_o), 32'h0);

        // Load a live instruction, stall, then reset between edges
        drive(32'h2128_FFFF, 32'h500, 1'b1);
        step();
        check("pre_reset.valid", 32'(valid_o), 32'd1);
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        expect_ctrl("async_reset", 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        check("async_reset.pc", pc_o, 32'h0000_3000);
        check("async_reset.imm", 32'(imm_o), 32'h0);
        check("async_reset.rs", 32'(rs_o), 32'd0);

        // Release with a valid instruction: loads on first edge after release
        stall = 1'b0;
        drive(32'h3C01_ABCD, 32'h600, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("post_release.valid", 32'(valid_o), 32'd0);
        step();
        check("first_load.valid", 32'(valid_o), 32'd1);
        check("first_load.pc", pc_o, 32'h600);
        check("first_load.alu_op", 32'(alu_op_o), 32'hC);
        check("first_load.waddr", 32'(waddr_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_alu_ctrl.md
Name: id_ex_alu_ctrl

Overview:
- ID→EX pipeline stage that produces the ALU control word for the execute stage.
- Decodes the fetched MIPS instruction into the 4-bit ALU op code and operand selects, then registers them with stall/flush control.
- Consumer side of the ALU interface; its outputs drive the ALU op input and the EX-stage operand muxes directly.
- Also flags overflow-trapping instructions and illegal encodings.

Parameters:
- PC_W, 32, width of the carried program counter.
- RESET_PC, 32'h0000_3000, value of pc_o on reset.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_i  input  32  instruction word from IF/ID.
- pc_i  input  PC_W  PC of instr_i.
- valid_i  input  1  instr_i is a real instruction (0 = bubble).
- stall  input  1  hold stage contents.
- flush  input  1  insert bubble; overrides stall.
- valid_o  output  1  registered instruction is live.
- pc_o  output  PC_W  registered PC.
- alu_op_o  output  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SRL, 5 SRA, 6 SLL, 7 SLT, 8 SLTU, 9 NOR, A XOR, B PASSA, C PASSB, D ROTR.
- a_sel_o  output  1  ALU A source: 0 = rs value, 1 = zero-extended shamt.
- b_sel_o  output  2  ALU B source: 0 = rt value, 1 = extended imm, 2 = imm<<16.
- ext_sign_o  output  1  imm extension: 1 = sign, 0 = zero.
- ov_en_o  output  1  ALU overflow raises an exception for this instruction.
- rw_en_o  output  1  writes the register file.
- waddr_o  output  5  destination register.
- rs_o, rt_o, shamt_o  output  5 each  instruction fields.
- imm_o  output  16  instruction[15:0].
- illegal_o  output  1  reserved-instruction exception.

Behaviour:
- Latency: 1 cycle. Decode is combinational from instr_i; all outputs are registered.
- Reset (asynchronous, immediate, no clock edge needed): every output is 0, except pc_o = RESET_PC.
- Priority on each rising edge: flush > stall > load.
  - flush: valid_o←0 and all control outputs cleared (pc_o keeps its value).
  - stall with no flush: every register holds.
  - otherwise: load the decoded word; valid_o←valid_i.
- Bubble rule: when the loaded valid_i=0, rw_en_o, ov_en_o and illegal_o are forced to 0. Field outputs are don't-care but must still be deterministic.
- R-type decode (opcode 0x00), by funct; shamt/rs distinguish rotates. A listed rs value (for immediate shifts) or shamt value (for variable shifts) must match exactly, otherwise illegal.
  - 20 ADD, ov_en=1. 21 ADD. 22 SUB, ov_en=1. 23 SUB.
  - 24 AND. 25 OR. 26 XOR. 27 NOR. 2A SLT. 2B SLTU.
  - 00 SLL, a_sel=1, rs=0. 02 a_sel=1: rs=0 → SRL, rs=1 → ROTR. 03 SRA, a_sel=1, rs=0.
  - 04 SLL. 06 shamt=0 → SRL, shamt=1 → ROTR. 07 SRA.
  - All R-type: waddr=rd, b_sel=0.
- I-type decode: waddr=rt, b_sel=1.
  - 08 ADD, sign, ov_en=1. 09 ADD, sign. 0A SLT, sign. 0B SLTU, sign.
  - 0C AND, zero. 0D OR, zero. 0E XOR, zero.
  - 0F PASSB, b_sel=2.
  - 23 (lw) ADD, sign, rw_en=1. 2B (sw) ADD, sign, rw_en=0.
  - 04/05 (beq/bne) SUB, b_sel=0, rw_en=0.
- Any other opcode/funct: illegal_o=1, rw_en=0, ov_en=0, alu_op=ADD.
- rw_en_o is forced to 0 whenever waddr=0, so nop (0x00000000) decodes as SLL with no write.
- Simultaneous stall and flush: flush wins.
- Reset mid-stall: reset wins and the held instruction is discarded.

Decomposition:
- Shared package alu_op_pkg holds:
  - ALU op code constants (used by the ALU and this stage);
  - opcode and funct constants;
  - a_sel and b_sel encodings;
  - packed typedef alu_ctrl_t = {alu_op, a_sel, b_sel, ext_sign, ov_en, rw_en, waddr, illegal}.
- One combinational sub-module, alu_op_decode (instr → alu_ctrl_t). id_ex_alu_ctrl instantiates it and owns the registers and stall/flush logic.

Test Plan:
- addi $8,$9,-1 (0x2128FFFF), valid_i=1 → next edge:
  - valid_o=1, alu_op=0, b_sel=1, ext_sign=1, ov_en=1, rw_en=1, waddr=8, rs=9, imm=FFFF.
- rotr $2,$3,4 (0x00231102) → alu_op=D, a_sel=1, shamt=4, waddr=2, illegal=0. Same word with rs field=2 (0x00431102) → illegal_o=1, rw_en=0.
- lui $1,0xABCD (0x3C01ABCD) → alu_op=C, b_sel=2, waddr=1.
- nop (0x00000000) → valid_o=1, alu_op=6, rw_en=0.
- Stall and pipeline control:
  - load addu, then stall=1 for 3 cycles while instr_i changes → outputs unchanged;
  - stall=1 with flush=1 → valid_o=0, rw_en=0 next edge;
  - opcode 0x3F (0xFC000000) → illegal_o=1.
- Reset behaviour:
  - assert reset between clock edges while valid_o=1 → all outputs 0 and pc_o=0x3000 immediately, with no clock edge;
  - release reset with a valid instruction → loads on the first edge after release.
